// File: rtl/mem_io_sequencer_if.sv
// CPU-side request/completion bus of mem_io_sequencer.
// Optional: MEM_IO_BYTE_EN_EN adds the be[1:0] byte-enable field.
//   req    request strobe (sampled by the sequencer only when idle)
//   we     1 = write, 0 = read
//   addr   request address
//   wdata  write data
//   be     byte enables (MEM_IO_BYTE_EN_EN only)
//   rdata  read data, held until the next read completes
//   ack    one-cycle completion pulse
//   busy   access in progress
// Modports: master = CPU side, slave = sequencer side.
interface mem_io_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
`ifdef MEM_IO_BYTE_EN_EN
  logic [1:0]        be;

  modport master (output req, we, addr, wdata, be, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack, busy);
`else
  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
`endif
endinterface

// File: rtl/mem_io_sequencer.sv
// Multi-cycle sequencer between the CPU memory port and an external async
// SRAM, with one memory-mapped IO address (reads: Switches, writes: hex_out).
// Optional: MEM_IO_BYTE_EN_EN enables per-byte UB/LB control and byte-masked
// hex_out writes; when undefined both byte lanes are always enabled.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       asynchronous active-low reset
//   bus         CPU request bus (slave modport): req/we/addr/wdata[/be] in,
//               rdata/ack/busy out
//   Switches    board switch value returned by IO reads
//   hex_out     hex display register loaded by IO writes
//   CE,OE,WE,   SRAM strobes, active-low
//   UB,LB
//   sram_addr   registered SRAM address
//   sram_wdata  registered SRAM write data
//   sram_rdata  data from the tristate read side
//   sram_drive  tristate output enable (1 = drive data bus)
//
// state  | meaning
// IDLE   | waiting for req; latches the request when it arrives
// SETUP  | one cycle of address/data setup, chip enabled, WE still high
// ACCESS | WAIT_CYCLES cycles of active read (OE low) or write (WE low)
// DONE   | ack pulse; write data held driven while WE is already high
module mem_io_sequencer #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 20'h0FFFF,
  parameter int                NUM_HEX     = 4,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  mem_io_sequencer_if.slave    bus,
  input  logic [DATA_W-1:0]    Switches,
  output logic [4*NUM_HEX-1:0] hex_out,
  output logic                 CE,
  output logic                 OE,
  output logic                 WE,
  output logic                 UB,
  output logic                 LB,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  output logic                 sram_drive
);

  localparam int HEX_W = 4 * NUM_HEX;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic             op_we;
  logic             op_io;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_io;
  logic             ub_n, lb_n;

  assign is_io = (bus.addr == IO_ADDR);

`ifdef MEM_IO_BYTE_EN_EN
  logic [1:0] be_q;
  assign ub_n = ~be_q[1];
  assign lb_n = ~be_q[0];
`else
  assign ub_n = 1'b0;
  assign lb_n = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.req) state_nx = is_io ? S_DONE : S_SETUP;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: if (wait_cnt == '0) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Strobes decode straight from the async-reset state register so a reset
  // mid-access releases the SRAM immediately.
  always_comb begin
    CE         = 1'b1;
    OE         = 1'b1;
    WE         = 1'b1;
    UB         = 1'b1;
    LB         = 1'b1;
    sram_drive = 1'b0;
    bus.ack    = 1'b0;
    bus.busy   = (state != S_IDLE);
    case (state)
      S_SETUP: begin
        CE = 1'b0;
        UB = ub_n;
        LB = lb_n;
        if (op_we) sram_drive = 1'b1;
        else       OE = 1'b0;
      end
      S_ACCESS: begin
        CE = 1'b0;
        UB = ub_n;
        LB = lb_n;
        if (op_we) begin
          WE         = 1'b0;
          sram_drive = 1'b1;
        end else begin
          OE = 1'b0;
        end
      end
      S_DONE: begin
        bus.ack = 1'b1;
        // Hold data one cycle past the WE rising edge for SRAM writes.
        if (op_we && !op_io) sram_drive = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_we      <= 1'b0;
      op_io      <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      wait_cnt   <= '0;
      bus.rdata  <= '0;
      hex_out    <= '0;
`ifdef MEM_IO_BYTE_EN_EN
      be_q       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            op_we      <= bus.we;
            op_io      <= is_io;
            sram_addr  <= bus.addr;
            sram_wdata <= bus.wdata;
`ifdef MEM_IO_BYTE_EN_EN
            be_q       <= bus.be;
`endif
            // IO accesses complete on the way into DONE.
            if (is_io) begin
              if (bus.we) begin
`ifdef MEM_IO_BYTE_EN_EN
                for (int i = 0; i < HEX_W; i++) begin
                  if (bus.be[(i < 8) ? 0 : 1]) hex_out[i] <= bus.wdata[i];
                end
`else
                hex_out <= bus.wdata[HEX_W-1:0];
`endif
              end else begin
                bus.rdata <= Switches;
              end
            end
          end
        end
        S_SETUP: wait_cnt <= CNT_LOAD;
        S_ACCESS: begin
          if (wait_cnt == '0) begin
            if (!op_we) bus.rdata <= sram_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_sequencer.sv
module tb_mem_io_sequencer;
  localparam int          DATA_W  = 16;
  localparam int          ADDR_W  = 20;
  localparam logic [19:0] IO_ADDR = 20'h0FFFF;
  localparam int          NUM_HEX = 4;
  localparam int          W       = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Switches;
  logic [15:0] hex_out;
  logic        CE, OE, WE, UB, LB;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_drive;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  mem_io_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_io_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_ADDR(IO_ADDR),
    .NUM_HEX(NUM_HEX), .WAIT_CYCLES(W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .Switches(Switches),
    .hex_out(hex_out), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_drive(sram_drive)
  );

  // ---------------- external SRAM device ----------------
  function automatic logic [15:0] init_val(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A ^ {12'h0, a[19:16]};
  endfunction

  logic [15:0] sram_mem [0:1048575];
  bit          sram_vld [0:1048575];

  always @(posedge Clk) begin
    if (Reset && !CE && !WE) begin
      sram_mem[sram_addr] <= {
        !UB ? sram_wdata[15:8] : (sram_vld[sram_addr] ? sram_mem[sram_addr][15:8] : init_val(sram_addr) >> 8),
        !LB ? sram_wdata[7:0]  : (sram_vld[sram_addr] ? sram_mem[sram_addr][7:0]  : 8'(init_val(sram_addr)))};
      sram_vld[sram_addr] <= 1'b1;
    end
  end

  always @(negedge Clk) begin
    sram_rdata <= (!CE && !OE) ? (sram_vld[sram_addr] ? sram_mem[sram_addr] : init_val(sram_addr))
                               : 16'hDEAD;
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [int];
  logic [15:0] ref_hex;
  logic [15:0] ref_rdata;

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_txn(input logic w, input logic [19:0] a, input logic [15:0] d,
                         input logic [1:0] b);
    int  cyc, ce_lo, oe_lo, we_lo, ovl, drv, lane_bad;
    bit  io;
    int  exp_lat;
    logic [15:0] old;
    logic exp_ub, exp_lb;
    io      = (a == IO_ADDR);
    exp_lat = io ? 1 : W + 2;
`ifdef MEM_IO_BYTE_EN_EN
    exp_ub = ~b[1];
    exp_lb = ~b[0];
`else
    exp_ub = 1'b0;
    exp_lb = 1'b0;
`endif
    if (w) begin
      if (io) begin
        ref_hex = {b[1] ? d[15:8] : ref_hex[15:8], b[0] ? d[7:0] : ref_hex[7:0]};
      end else begin
        old = ref_rd(a);
        ref_mem[int'(a)] = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
      end
    end else begin
      ref_rdata = io ? Switches : ref_rd(a);
    end

    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
`ifdef MEM_IO_BYTE_EN_EN
    bus.be = b;
`endif
    tick();
    bus.req = 1'b0;
    cyc = 1; ce_lo = 0; oe_lo = 0; we_lo = 0; ovl = 0; drv = 0; lane_bad = 0;
    forever begin
      if (!CE) ce_lo++;
      if (!OE) oe_lo++;
      if (!WE) we_lo++;
      if (!WE && !OE) ovl++;
      if (sram_drive) drv++;
      if (!CE && (UB !== exp_ub || LB !== exp_lb)) lane_bad++;
      if (CE && !(UB && LB)) lane_bad++;
      if (bus.ack === 1'b1 || cyc >= 40) break;
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("busy_at_ack", 32'(bus.busy), 32'd1);
    check("rdata", 32'(bus.rdata), 32'(ref_rdata));
    check("sram_addr", 32'(sram_addr), 32'(a));
    check("ce_low_cycles", 32'(ce_lo), io ? 32'd0 : 32'(W + 1));
    check("oe_low_cycles", 32'(oe_lo), (io || w) ? 32'd0 : 32'(W + 1));
    check("we_low_cycles", 32'(we_lo), (io || !w) ? 32'd0 : 32'(W));
    check("we_oe_overlap", 32'(ovl), 32'd0);
    check("drive_cycles", 32'(drv), (io || !w) ? 32'd0 : 32'(W + 2));
    check("byte_lanes", 32'(lane_bad), 32'd0);
    tick();
    check("ack_one_cycle", 32'(bus.ack), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("hex_out", 32'(hex_out), 32'(ref_hex));
  endtask

  initial begin
    int acks, ack_t[$], n;
    logic [19:0] ra;
    logic        rw;
    logic [1:0]  rb;

    Reset = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
`ifdef MEM_IO_BYTE_EN_EN
    bus.be = 2'b11;
`endif
    Switches  = 16'h0000;
    ref_hex   = 16'h0000;
    ref_rdata = 16'h0000;

    #12;
    check("rst_strobes", 32'({CE, OE, WE, UB, LB}), 32'h1F);
    check("rst_drive", 32'(sram_drive), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_hex", 32'(hex_out), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_wdata", 32'(sram_wdata), 32'd0);
    @(negedge Clk); Reset = 1'b1;
    tick();

    // Reset in the middle of a write access.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 20'h00010; bus.wdata = 16'h1111;
    tick();
    bus.req = 1'b0;
    tick();
    check("abort_we_active", 32'(WE), 32'd0);
    #2 Reset = 1'b0;
    #1;
    check("abort_ce", 32'(CE), 32'd1);
    check("abort_we", 32'(WE), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_drive", 32'(sram_drive), 32'd0);
    @(negedge Clk); Reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ack) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    run_txn(1'b0, 20'h00002, 16'h0000, 2'b11);

    // SRAM write then read-back.
    run_txn(1'b1, 20'h00123, 16'hBEEF, 2'b11);
    run_txn(1'b0, 20'h00123, 16'h0000, 2'b11);
    check("readback", 32'(bus.rdata), 32'hBEEF);

    // IO read and write.
    Switches = 16'h1234;
    run_txn(1'b0, IO_ADDR, 16'h0000, 2'b11);
    check("io_read", 32'(bus.rdata), 32'h1234);
    run_txn(1'b1, IO_ADDR, 16'h0ABC, 2'b11);
    check("io_write", 32'(hex_out), 32'h0ABC);

    // req held high: three back-to-back reads of address 0.
    ref_rdata = ref_rd(20'h00000);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 20'h00000;
    tick();
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.ack) begin
        ack_t.push_back(c);
        n++;
        if (n == 3) bus.req = 1'b0;
      end
      tick();
    end
    check("held_ack_count", 32'(ack_t.size()), 32'd3);
    if (ack_t.size() == 3) begin
      check("held_first", 32'(ack_t[0]), 32'(W + 2));
      check("held_gap1", 32'(ack_t[1] - ack_t[0]), 32'(W + 3));
      check("held_gap2", 32'(ack_t[2] - ack_t[1]), 32'(W + 3));
    end
    check("held_rdata", 32'(bus.rdata), 32'(ref_rdata));

    // req pulse while busy must be ignored.
    ref_rdata = ref_rd(20'h00001);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 20'h00001;
    tick();
    bus.req = 1'b0;
    acks = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = IO_ADDR; bus.wdata = 16'hFFFF;
      end else begin
        bus.req = 1'b0;
      end
      if (bus.ack) acks++;
      tick();
    end
    check("busy_req_acks", 32'(acks), 32'd1);
    check("busy_req_hex", 32'(hex_out), 32'(ref_hex));
    check("busy_req_addr", 32'(sram_addr), 32'h00001);
    check("busy_req_rdata", 32'(bus.rdata), 32'(ref_rdata));

`ifdef MEM_IO_BYTE_EN_EN
    run_txn(1'b1, 20'h00003, 16'hAA55, 2'b10);
    run_txn(1'b1, IO_ADDR, 16'h7788, 2'b01);
    check("be_hex", 32'(hex_out), 32'h0A88);
    run_txn(1'b1, 20'h00002, 16'h1357, 2'b00);
    run_txn(1'b0, 20'h00003, 16'h0000, 2'b11);
    run_txn(1'b0, 20'h00002, 16'h0000, 2'b11);
`endif

    // Randomized mix checked against the reference model.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: ra = 20'($urandom_range(0, 3));
        4:          ra = IO_ADDR;
        5:          ra = IO_ADDR + 20'd1;
        6:          ra = 20'hFFFFF;
        default:    ra = 20'h00123;
      endcase
      rw       = 1'($urandom_range(0, 1));
      Switches = 16'($urandom);
`ifdef MEM_IO_BYTE_EN_EN
      rb = 2'($urandom_range(0, 3));
`else
      rb = 2'b11;
`endif
      run_txn(rw, ra, 16'($urandom), rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_io_sequencer.md
Name: mem_io_sequencer

Overview:
- Parametrised successor to the single-cycle SRAM/IO glue between the SLC-3 datapath and the external 1Mx16 async SRAM.
- Accepts one CPU memory request at a time and runs a multi-cycle SRAM access with programmable wait states.
- Decodes one memory-mapped IO address: reads return the switch value, writes load the hex-display register.
- Reports completion with a one-cycle ack, so the ISDU no longer relies on fixed memory-state counts.

Parameters:
DATA_W, 16, data width of CPU and SRAM buses
ADDR_W, 20, SRAM address width
IO_ADDR, 20'h0FFFF, address decoded as switch/hex IO instead of SRAM
NUM_HEX, 4, hex digits held in the display register (4 bits each, 4*NUM_HEX <= DATA_W)
WAIT_CYCLES, 2, cycles in ACCESS state (>=1)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous active-low reset
req  in  1  request strobe, sampled only in IDLE
we  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  request address, sampled with req
wdata  in  DATA_W  write data, sampled with req
rdata  out  DATA_W  read data, valid while ack=1, held until next read completes
ack  out  1  one-cycle completion pulse
busy  out  1  high from acceptance until the cycle after ack
Switches  in  DATA_W  board switches
hex_out  out  4*NUM_HEX  display register
CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low
sram_addr  out  ADDR_W  registered SRAM address
sram_wdata  out  DATA_W  registered write data
sram_rdata  in  DATA_W  data from tristate read side
sram_drive  out  1  tristate output enable (1 = drive Data)

Behaviour:
- Reset (Reset=0, async): state IDLE.
  - CE=OE=WE=UB=LB=1; sram_drive=0.
  - ack=0, busy=0; rdata, hex_out, sram_addr and sram_wdata all 0.
  - Reset mid-access aborts immediately. No ack. Strobes deassert asynchronously.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On req=1, latch we/addr/wdata into sram_addr/sram_wdata/op registers and set busy=1.
  - If addr==IO_ADDR, go to DONE; otherwise go to SETUP.
  - req=0: stay.
- SETUP (1 cycle): CE=0, UB=LB=0. For a read OE=0; for a write sram_drive=1 with WE still 1 (address/data setup). Next state ACCESS; load wait counter with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - Read: CE=0, OE=0.
  - Write: CE=0, WE=0, sram_drive=1.
  - Counter decrements each cycle. At count 0 the next state is DONE; a read captures sram_rdata into rdata on that edge.
- DONE (1 cycle):
  - ack=1. CE=OE=WE=1 (write hold: sram_drive stays 1, WE already high).
  - For an IO read, rdata <= Switches on entry. For an IO write, hex_out <= wdata[4*NUM_HEX-1:0] on entry.
  - Next state IDLE, busy=0.
- Latency (req sampled at edge 0):
  - SRAM read/write: ack high in cycle WAIT_CYCLES+2.
  - IO access: ack high in cycle 1.
- req while busy is ignored and not queued. req held high through DONE is re-accepted in IDLE, giving back-to-back accesses with one IDLE cycle between acks.
- WE is never low in the same cycle as OE. WE is never low outside ACCESS.
- IO accesses never assert CE.
- Addresses above IO_ADDR go to SRAM normally. Address width is not wrapped or truncated.

Optional Feature:
- Macro MEM_IO_BYTE_EN_EN.
- Defined:
  - Adds input be [1:0], sampled with req.
  - UB = ~be[1], LB = ~be[0] during SETUP/ACCESS.
  - be=2'b00 completes with ack but leaves UB=LB=1.
  - IO writes update only the enabled bytes of hex_out.
- Undefined: no be port; UB=LB=0 for every SRAM access.

Test Plan:
1. Reset=0 mid-ACCESS of a write to 20'h00010 -> CE, WE go 1 asynchronously; no ack; busy=0; next req is served normally.
2. WAIT_CYCLES=2: write 16'hBEEF to 20'h00123, then read it back -> WE low exactly 2 cycles, OE high throughout the write; read ack in cycle 4 with rdata=16'hBEEF.
3. Read IO_ADDR with Switches=16'h1234 -> ack in cycle 1, rdata=16'h1234, CE stays 1.
4. Write 16'h0ABC to IO_ADDR -> hex_out=16'h0ABC after ack; SRAM strobes untouched.
5. req held high for 3 reads of 20'h00000 -> exactly 3 ack pulses spaced WAIT_CYCLES+3 apart; a req pulse during busy is ignored.
6. With MEM_IO_BYTE_EN_EN: write be=2'b10, data 16'hAA55 -> UB=0, LB=1 during ACCESS; an IO write with be=2'b01 updates only hex_out[7:0].
